// File: rtl/gnn_load_pkg.sv
// Shared types for the GNN DRAM->buffer load engine: FSM states and the LOAD instruction layout.
package gnn_load_pkg;

  localparam int GROUP_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_STREAM,
    S_DRAIN,
    S_FINISH
  } load_state_e;

  typedef struct packed {
    logic [31:0]        dram_start;
    logic [15:0]        dram_bytes;
    logic [15:0]        rsvd1;
    logic [15:0]        buf_len;
    logic [15:0]        buf_start;
    logic [25:0]        rsvd0;
    logic [GROUP_W-1:0] group;
  } load_inst_t;

  // A group selects exactly one existing buffer.
  function automatic logic group_legal(input logic [GROUP_W-1:0] group, input int num_buf);
    return $onehot(group) && ((group >> num_buf) == '0);
  endfunction

endpackage

// File: rtl/gnn_load_wr_stage.sv
// One-entry buffer-write register: loads a stream beat, holds it until the selected buffer accepts.
// Zero bubble: a new beat loads in the same cycle the held one retires.
module gnn_load_wr_stage
  import gnn_load_pkg::*;
#(
  parameter int NUM_BUF    = 5,
  parameter int BUF_ADDR_W = 11,
  parameter int DATA_W     = 512
) (
  input  logic                  kernel_clk,
  input  logic                  kernel_rst,
  input  logic [NUM_BUF-1:0]    sel,
  input  logic                  beat_valid,
  output logic                  beat_ready,
  input  logic [BUF_ADDR_W-1:0] beat_addr,
  input  logic [DATA_W-1:0]     beat_data,
  output logic                  pending,
  output logic                  retire,
  output logic [NUM_BUF-1:0]    buf_wr_valid,
  input  logic [NUM_BUF-1:0]    buf_wr_ready,
  output logic [BUF_ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0]     buf_wr_data
);

  logic valid_q;

  assign retire       = valid_q && |(buf_wr_ready & sel);
  assign beat_ready   = !valid_q || retire;
  assign pending      = valid_q;
  assign buf_wr_valid = valid_q ? sel : '0;

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      valid_q     <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
    end else if (beat_valid && beat_ready) begin
      valid_q     <= 1'b1;
      buf_wr_addr <= beat_addr;
      buf_wr_data <= beat_data;
    end else if (retire) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/gnn_load_unit.sv
// LOAD engine: one instruction -> one DRAM read request -> returned beats steered to one buffer.
// Stream accept to buffer strobe is 1 cycle; s_tready follows the write register's ability to take a beat.
module gnn_load_unit #(
  parameter int NUM_BUF    = 5,
  parameter int BUF_ADDR_W = 11,
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 64,
  parameter int XFER_W     = 32,
  parameter int INST_W     = 128
) (
  input  logic                  kernel_clk,
  input  logic                  kernel_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_err,
  input  logic [ADDR_W-1:0]     ctrl_addr_offset,
  input  logic [INST_W-1:0]     ctrl_instruction,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_W-1:0]     rd_req_addr,
  output logic [XFER_W-1:0]     rd_req_bytes,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [DATA_W-1:0]     s_tdata,
  output logic [NUM_BUF-1:0]    buf_wr_valid,
  input  logic [NUM_BUF-1:0]    buf_wr_ready,
  output logic [BUF_ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0]     buf_wr_data
);
  import gnn_load_pkg::*;

  load_state_e        state_q, state_d;
  load_inst_t         inst_in;
  logic [ADDR_W-1:0]  offset_q;
  logic [GROUP_W-1:0] group_q;
  logic [15:0]        buf_start_q, buf_len_q, dram_bytes_q, cnt_q;
  logic [31:0]        dram_start_q;
  logic [NUM_BUF-1:0] sel_q;
  logic               err_q, discard_q;
  logic               legal, last_beat, beat_valid, beat_ready, beat_fire;
  logic               pending, retire, drain_end;
  logic               unused_inst;

  assign inst_in     = load_inst_t'(ctrl_instruction);
  assign unused_inst = ^{inst_in.rsvd0, inst_in.rsvd1};

  assign legal       = group_legal(group_q, NUM_BUF);
  assign last_beat   = (cnt_q == buf_len_q - 16'd1);
  assign beat_valid  = (state_q == S_STREAM) && s_tvalid;
  assign beat_fire   = beat_valid && beat_ready;
  // Leave DRAIN once the tail is dropped and the final buffer write is taken.
  assign drain_end   = (!discard_q || (s_tvalid && s_tlast)) && (!pending || retire);

  assign rd_req_addr  = offset_q + ADDR_W'(dram_start_q);
  assign rd_req_bytes = XFER_W'(dram_bytes_q);

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ap_start) state_d = S_CHECK;
      S_CHECK:  state_d = (!legal || buf_len_q == 16'd0) ? S_FINISH : S_REQ;
      S_REQ:    if (rd_req_ready) state_d = S_STREAM;
      S_STREAM: if (beat_fire && (last_beat || s_tlast)) state_d = S_DRAIN;
      S_DRAIN:  if (drain_end) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ap_ready     = (state_q == S_IDLE);
    ap_done      = (state_q == S_FINISH);
    ap_err       = (state_q == S_FINISH) && err_q;
    rd_req_valid = (state_q == S_REQ);
    s_tready     = ((state_q == S_STREAM) && beat_ready) || ((state_q == S_DRAIN) && discard_q);
  end

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      offset_q     <= '0;
      group_q      <= '0;
      buf_start_q  <= '0;
      buf_len_q    <= '0;
      dram_bytes_q <= '0;
      dram_start_q <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (ap_start) begin
          offset_q     <= ctrl_addr_offset;
          group_q      <= inst_in.group;
          buf_start_q  <= inst_in.buf_start;
          buf_len_q    <= inst_in.buf_len;
          dram_bytes_q <= inst_in.dram_bytes;
          dram_start_q <= inst_in.dram_start;
          cnt_q        <= '0;
          err_q        <= 1'b0;
          discard_q    <= 1'b0;
        end
        S_CHECK: begin
          sel_q <= group_q[NUM_BUF-1:0];
          if (!legal) err_q <= 1'b1;
        end
        S_STREAM: if (beat_fire) begin
          cnt_q <= cnt_q + 16'd1;
          if (last_beat)    discard_q <= !s_tlast;
          else if (s_tlast) err_q     <= 1'b1;
        end
        S_DRAIN: if (discard_q && s_tvalid && s_tlast) discard_q <= 1'b0;
        default: ;
      endcase
    end
  end

  gnn_load_wr_stage #(
    .NUM_BUF   (NUM_BUF),
    .BUF_ADDR_W(BUF_ADDR_W),
    .DATA_W    (DATA_W)
  ) u_wr_stage (
    .kernel_clk  (kernel_clk),
    .kernel_rst  (kernel_rst),
    .sel         (sel_q),
    .beat_valid  (beat_valid),
    .beat_ready  (beat_ready),
    .beat_addr   (BUF_ADDR_W'(buf_start_q + cnt_q)),
    .beat_data   (s_tdata),
    .pending     (pending),
    .retire      (retire),
    .buf_wr_valid(buf_wr_valid),
    .buf_wr_ready(buf_wr_ready),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data)
  );

endmodule

// File: tb/tb_gnn_load_unit.sv
// Scenario bench for gnn_load_unit: buffer writes are predicted when beats are driven and retired by a monitor.
module tb_gnn_load_unit;

  localparam int NUM_BUF    = 5;
  localparam int BUF_ADDR_W = 11;
  localparam int DATA_W     = 512;
  localparam int ADDR_W     = 64;
  localparam int XFER_W     = 32;
  localparam int INST_W     = 128;
  localparam int NO_TLAST   = 100000;

  typedef struct packed {
    logic [NUM_BUF-1:0]    oh;
    logic [BUF_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_exp_t;

  logic                  kernel_clk = 1'b0;
  logic                  kernel_rst;
  logic                  ap_start, ap_ready, ap_done, ap_err;
  logic [ADDR_W-1:0]     ctrl_addr_offset;
  logic [INST_W-1:0]     ctrl_instruction;
  logic                  rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0]     rd_req_addr;
  logic [XFER_W-1:0]     rd_req_bytes;
  logic                  s_tvalid, s_tready, s_tlast;
  logic [DATA_W-1:0]     s_tdata;
  logic [NUM_BUF-1:0]    buf_wr_valid, buf_wr_ready;
  logic [BUF_ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0]     buf_wr_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int wr_count = 0, rd_count = 0, done_count = 0, beat_count = 0;
  int done_cyc = 0, tlast_cyc = 0, stall_cyc = 0, bp_viol = 0;
  logic done_err = 1'b0;
  logic [ADDR_W-1:0] rd_addr_seen = '0;
  logic [XFER_W-1:0] rd_bytes_seen = '0;
  wr_exp_t exp_q[$];
  wr_exp_t mon_e;

  gnn_load_unit #(
    .NUM_BUF(NUM_BUF), .BUF_ADDR_W(BUF_ADDR_W), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .XFER_W(XFER_W), .INST_W(INST_W)
  ) dut (
    .kernel_clk(kernel_clk), .kernel_rst(kernel_rst),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_err(ap_err),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_bytes(rd_req_bytes),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .buf_wr_valid(buf_wr_valid), .buf_wr_ready(buf_wr_ready),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data)
  );

  always #5 kernel_clk = ~kernel_clk;
  always @(posedge kernel_clk) cyc = cyc + 1;

  // Monitor: retires predicted writes and records handshake events, sampled mid-cycle.
  always @(negedge kernel_clk) begin
    if (!kernel_rst) begin
      if (|(buf_wr_valid & buf_wr_ready)) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got sel=%b addr=%h with no write pending in the scoreboard",
                   buf_wr_valid, buf_wr_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (buf_wr_valid !== mon_e.oh || buf_wr_addr !== mon_e.addr || buf_wr_data !== mon_e.data) begin
            fails++;
            $display("FAIL wr_beat: got sel=%b addr=%h data=%h, expected sel=%b addr=%h data=%h",
                     buf_wr_valid, buf_wr_addr, buf_wr_data[63:0], mon_e.oh, mon_e.addr, mon_e.data[63:0]);
          end
        end
        wr_count++;
      end
      if (|(buf_wr_valid & ~buf_wr_ready)) begin
        stall_cyc++;
        if (s_tready) bp_viol++;
      end
      if (rd_req_valid && rd_req_ready) begin
        rd_count++;
        rd_addr_seen  = rd_req_addr;
        rd_bytes_seen = rd_req_bytes;
      end
      if (s_tvalid && s_tready) begin
        beat_count++;
        if (s_tlast) tlast_cyc = cyc;
      end
      if (ap_done) begin
        done_count++;
        done_err = ap_err;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not produced");
    $fatal(1, "watchdog");
  end

  function automatic logic [INST_W-1:0] make_inst(input logic [5:0] group, input logic [15:0] bstart,
                                                  input logic [15:0] blen, input logic [15:0] dbytes,
                                                  input logic [31:0] dstart);
    return {dstart, dbytes, 16'h0000, blen, bstart, 26'h0, group};
  endfunction

  task automatic issue(input logic [5:0] group, input logic [15:0] bstart, input logic [15:0] blen,
                       input logic [15:0] dbytes, input logic [31:0] dstart, input logic [ADDR_W-1:0] off);
    @(posedge kernel_clk); #1;
    ctrl_addr_offset = off;
    ctrl_instruction = make_inst(group, bstart, blen, dbytes, dstart);
    ap_start   = 1'b1;
    accept_cyc = cyc;
    @(posedge kernel_clk); #1;
    ap_start         = 1'b0;
    ctrl_addr_offset = {$urandom, $urandom};
    ctrl_instruction = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Drives n beats; beats the DUT should write (k < len, up to tlast) are pushed to the scoreboard.
  task automatic send_beats(input int n, input int len, input int tlast_at, input int gap,
                            input logic [NUM_BUF-1:0] oh, input logic [15:0] start);
    wr_exp_t e;
    bit ok;
    for (int k = 0; k < n; k++) begin
      logic [DATA_W-1:0] d;
      for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
      if (k < len && k <= tlast_at) begin
        e.oh   = oh;
        e.addr = BUF_ADDR_W'(start + k);
        e.data = d;
        exp_q.push_back(e);
      end
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = (k == tlast_at);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge kernel_clk);
        if (s_tready) ok = 1'b1;
        @(posedge kernel_clk); #1;
      end
      if (!ok) begin
        tests++; fails++;
        $display("FAIL beat_timeout: beat %0d not accepted within 200 cycles, s_tready=%b", k, s_tready);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (gap) @(posedge kernel_clk);
      if (gap > 0) #1;
    end
  endtask

  task automatic wait_done(input int base, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge kernel_clk);
      if (done_count > base) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    kernel_rst = 1'b1;
    repeat (3) @(posedge kernel_clk);
    #1;
    tests++; if (ap_ready !== 1'b1) begin fails++; $display("FAIL reset_ap_ready: got %b, expected 1", ap_ready); end
    tests++; if (ap_done !== 1'b0) begin fails++; $display("FAIL reset_ap_done: got %b, expected 0", ap_done); end
    tests++; if (ap_err !== 1'b0) begin fails++; $display("FAIL reset_ap_err: got %b, expected 0", ap_err); end
    tests++; if (rd_req_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_req_valid: got %b, expected 0", rd_req_valid); end
    tests++; if (buf_wr_valid !== '0) begin fails++; $display("FAIL reset_buf_wr_valid: got %b, expected 0", buf_wr_valid); end
    tests++; if (buf_wr_addr !== '0 || buf_wr_data !== '0) begin fails++; $display("FAIL reset_wr_addr_data: got addr=%h data=%h, expected 0", buf_wr_addr, buf_wr_data[63:0]); end
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready: got %b, expected 0", s_tready); end
    tests++; if (rd_req_addr !== '0) begin fails++; $display("FAIL reset_rd_req_addr: got %h, expected 0", rd_req_addr); end
    kernel_rst = 1'b0;
  endtask

  task automatic test_wrap_stream;
    int wr0 = wr_count, rd0 = rd_count, dn0 = done_count;
    bit seen;
    logic [ADDR_W-1:0] off = 64'h0000_0001_0000_0000;
    rd_req_ready = 1'b0;
    issue(6'b000010, 16'h07F0, 16'd32, 16'd2048, 32'h0000_1000, off);
    @(posedge kernel_clk); #1;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (rd_req_valid !== 1'b1 || rd_req_addr !== off + 64'h1000 || rd_req_bytes !== 32'd2048) begin
        fails++;
        $display("FAIL wrap_req_hold: got valid=%b addr=%h bytes=%0d, expected 1 %h 2048",
                 rd_req_valid, rd_req_addr, rd_req_bytes, off + 64'h1000);
      end
      @(posedge kernel_clk); #1;
    end
    rd_req_ready = 1'b1;
    send_beats(32, 32, 31, 0, 5'b00010, 16'h07F0);
    wait_done(dn0, seen);
    tests++; if (!seen || done_err !== 1'b0) begin fails++; $display("FAIL wrap_done: got seen=%b err=%b, expected 1 0", seen, done_err); end
    tests++; if (wr_count - wr0 != 32 || exp_q.size() != 0) begin fails++; $display("FAIL wrap_writes: got %0d writes, %0d left, expected 32 and 0", wr_count - wr0, exp_q.size()); end
    tests++; if (rd_count - rd0 != 1 || rd_addr_seen !== off + 64'h1000 || rd_bytes_seen !== 32'd2048) begin fails++; $display("FAIL wrap_request: got %0d reqs addr=%h bytes=%0d, expected 1 %h 2048", rd_count - rd0, rd_addr_seen, rd_bytes_seen, off + 64'h1000); end
  endtask

  task automatic test_backpressure;
    int wr0 = wr_count, dn0 = done_count, st0 = stall_cyc, bv0 = bp_viol;
    bit seen;
    issue(6'b000001, 16'h0100, 16'd4, 16'd256, 32'h0000_2000, 64'h40);
    fork
      send_beats(4, 4, 3, 0, 5'b00001, 16'h0100);
      for (int c = 0; c < 40; c++) begin
        @(posedge kernel_clk); #1;
        buf_wr_ready[0] = ~buf_wr_ready[0];
      end
    join
    buf_wr_ready = '1;
    wait_done(dn0, seen);
    tests++; if (!seen || done_err !== 1'b0) begin fails++; $display("FAIL bp_done: got seen=%b err=%b, expected 1 0", seen, done_err); end
    tests++; if (wr_count - wr0 != 4 || exp_q.size() != 0) begin fails++; $display("FAIL bp_writes: got %0d writes, %0d left, expected 4 and 0", wr_count - wr0, exp_q.size()); end
    tests++; if (bp_viol != bv0 || stall_cyc == st0) begin fails++; $display("FAIL bp_tready: got %0d tready-while-stalled over %0d stall cycles, expected 0 over >0", bp_viol - bv0, stall_cyc - st0); end
  endtask

  task automatic test_illegal_group;
    logic [5:0] groups [2];
    groups[0] = 6'b000011;
    groups[1] = 6'b100000;
    for (int g = 0; g < 2; g++) begin
      int rd0 = rd_count, dn0 = done_count, wr0 = wr_count;
      bit seen;
      issue(groups[g], 16'h0, 16'd4, 16'd256, 32'h0, 64'h0);
      wait_done(dn0, seen);
      tests++; if (!seen || done_err !== 1'b1) begin fails++; $display("FAIL illegal_err: group=%b got seen=%b err=%b, expected 1 1", groups[g], seen, done_err); end
      // accept cycle, CHECK, then FINISH
      tests++; if (done_cyc - accept_cyc != 2) begin fails++; $display("FAIL illegal_timing: group=%b got done %0d cycles past accept cycle, expected 2", groups[g], done_cyc - accept_cyc); end
      tests++; if (rd_count != rd0 || wr_count != wr0) begin fails++; $display("FAIL illegal_no_req: group=%b got %0d reqs %0d writes, expected 0 0", groups[g], rd_count - rd0, wr_count - wr0); end
    end
  endtask

  task automatic test_len_zero_and_drain;
    int rd0 = rd_count, dn0 = done_count, wr0, bt0;
    bit seen;
    issue(6'b000100, 16'h0, 16'd0, 16'd0, 32'h0, 64'h0);
    wait_done(dn0, seen);
    tests++; if (!seen || done_err !== 1'b0 || rd_count != rd0) begin fails++; $display("FAIL len0: got seen=%b err=%b reqs=%0d, expected 1 0 0", seen, done_err, rd_count - rd0); end
    wr0 = wr_count; bt0 = beat_count; dn0 = done_count;
    issue(6'b001000, 16'h0020, 16'd4, 16'd384, 32'h0000_3000, 64'h0);
    send_beats(6, 4, 5, 0, 5'b01000, 16'h0020);
    wait_done(dn0, seen);
    tests++; if (!seen || done_err !== 1'b0) begin fails++; $display("FAIL drain_done: got seen=%b err=%b, expected 1 0", seen, done_err); end
    tests++; if (wr_count - wr0 != 4 || beat_count - bt0 != 6) begin fails++; $display("FAIL drain_counts: got %0d writes %0d beats, expected 4 6", wr_count - wr0, beat_count - bt0); end
    tests++; if (done_cyc <= tlast_cyc) begin fails++; $display("FAIL drain_order: got done cycle %0d, tlast cycle %0d, expected done later", done_cyc, tlast_cyc); end
  endtask

  task automatic test_early_tlast;
    int rd0 = rd_count, dn0 = done_count, wr0 = wr_count;
    bit seen;
    issue(6'b010000, 16'h0200, 16'd8, 16'd512, 32'h0000_4000, 64'h0);
    fork
      send_beats(3, 8, 2, 3, 5'b10000, 16'h0200);
      begin
        repeat (6) @(posedge kernel_clk);
        #1;
        tests++; if (ap_ready !== 1'b0) begin fails++; $display("FAIL busy_ready: got ap_ready=%b mid-stream, expected 0", ap_ready); end
        ctrl_instruction = make_inst(6'b000001, 16'h0, 16'd4, 16'd64, 32'h0);
        ap_start = 1'b1;
        @(posedge kernel_clk); #1;
        ap_start = 1'b0;
      end
    join
    wait_done(dn0, seen);
    tests++; if (!seen || done_err !== 1'b1) begin fails++; $display("FAIL early_err: got seen=%b err=%b, expected 1 1", seen, done_err); end
    tests++; if (wr_count - wr0 != 3 || exp_q.size() != 0) begin fails++; $display("FAIL early_writes: got %0d writes, %0d left, expected 3 0", wr_count - wr0, exp_q.size()); end
    repeat (10) @(posedge kernel_clk);
    #1;
    tests++; if (done_count - dn0 != 1 || rd_count - rd0 != 1 || ap_ready !== 1'b1) begin fails++; $display("FAIL start_ignored: got %0d dones %0d reqs ready=%b, expected 1 1 1", done_count - dn0, rd_count - rd0, ap_ready); end
  endtask

  task automatic test_reset_mid_stream;
    int dn0 = done_count, wr0;
    bit seen;
    issue(6'b000100, 16'h0300, 16'd16, 16'd1024, 32'h0000_5000, 64'h0);
    send_beats(5, 16, NO_TLAST, 0, 5'b00100, 16'h0300);
    kernel_rst = 1'b1;
    #1;
    tests++;
    if (ap_ready !== 1'b1 || ap_done !== 1'b0 || rd_req_valid !== 1'b0 || buf_wr_valid !== '0 || s_tready !== 1'b0 || buf_wr_addr !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: got ready=%b done=%b req=%b wr=%b tready=%b addr=%h, expected 1 0 0 0 0 0",
               ap_ready, ap_done, rd_req_valid, buf_wr_valid, s_tready, buf_wr_addr);
    end
    exp_q.delete();
    repeat (2) @(posedge kernel_clk);
    #1;
    kernel_rst = 1'b0;
    tests++; if (done_count != dn0) begin fails++; $display("FAIL midrst_no_done: got %0d dones, expected 0", done_count - dn0); end
    wr0 = wr_count;
    issue(6'b010000, 16'h07FE, 16'd4, 16'd256, 32'h0000_6000, 64'h80);
    send_beats(4, 4, 3, 1, 5'b10000, 16'h07FE);
    wait_done(dn0, seen);
    tests++; if (!seen || done_err !== 1'b0 || wr_count - wr0 != 4 || exp_q.size() != 0) begin fails++; $display("FAIL midrst_recover: got seen=%b err=%b writes=%0d left=%0d, expected 1 0 4 0", seen, done_err, wr_count - wr0, exp_q.size()); end
    tests++; if (rd_addr_seen !== 64'h6080) begin fails++; $display("FAIL midrst_req_addr: got %h, expected 6080", rd_addr_seen); end
  endtask

  initial begin
    kernel_rst       = 1'b1;
    ap_start         = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_instruction = '0;
    rd_req_ready     = 1'b1;
    s_tvalid         = 1'b0;
    s_tlast          = 1'b0;
    s_tdata          = '0;
    buf_wr_ready     = '1;
    test_reset();
    test_wrap_stream();
    test_backpressure();
    test_illegal_group();
    test_len_zero_and_drain();
    test_early_tlast();
    test_reset_mid_stream();
    repeat (5) @(posedge kernel_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
